// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: types shared by the SPI RAM loader and dumper.
// FSM states, SPI mode and the address-byte helper.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    FETCH,
    DATA
  } state_t;

  localparam int unsigned SPI_MODE = 0;

  function automatic int unsigned addr_bytes(
    input int unsigned aw
  );
    return (aw + 7) / 8;
  endfunction

endpackage

// File: rtl/spi_ram_dumper_if.sv
// spi_ram_dumper_if: SRAM read port between dumper and memory.
// The dumper is master; the memory answers one cycle after ren.
interface spi_ram_dumper_if #(
  parameter int AW = 8
);

  logic [AW-1:0] sram_raddr;
  logic          sram_ren;
  logic [7:0]    sram_rdata;

  modport master (
    output sram_raddr,
    output sram_ren,
    input  sram_rdata
  );

  modport slave (
    input  sram_raddr,
    input  sram_ren,
    output sram_rdata
  );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with rise/fall detect.
// RST_VAL sets the idle level the flops reset to.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_ram_dumper.sv
// spi_ram_dumper: SPI mode-0 target streaming SRAM bytes on MISO.
// Define SPI_RAM_DUMPER_MISO_OE_EN to add the o_miso_oe port.
module spi_ram_dumper
  import spi_ram_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_miso,
`ifdef SPI_RAM_DUMPER_MISO_OE_EN
  output logic o_miso_oe,
`endif
  spi_ram_dumper_if.master sram
);

  localparam int ADDR_BYTES = int'(addr_bytes(AW));
  localparam int ABITS      = 8 * ADDR_BYTES;

  state_t        state, state_n;
  logic [4:0]    acnt, acnt_n;
  logic [AW-1:0] asr, asr_n;
  logic [AW-1:0] raddr_n;
  logic          ren_n, ren_d;
  logic [7:0]    sr, sr_n;
  logic [7:0]    pbuf, pbuf_n;
  logic [2:0]    bcnt, bcnt_n;
  logic          smp, smp_n;
  logic          miso_n;

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s1, mosi_s2;
  logic [1:0] warm;
  logic armed;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (i_sclk),
    .q    (sclk_lvl_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (i_cs_n),
    .q    (cs_lvl),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // A select only counts once cs_n was seen high after reset,
  // so releasing reset under a held-low cs_n does not start a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      warm    <= '0;
      armed   <= 1'b0;
    end else begin
      mosi_s1 <= i_mosi;
      mosi_s2 <= mosi_s1;
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (warm == 2'd3 && cs_lvl) armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      acnt            <= '0;
      asr             <= '0;
      sram.sram_raddr <= '0;
      sram.sram_ren   <= 1'b0;
      ren_d           <= 1'b0;
      sr              <= '0;
      pbuf            <= '0;
      bcnt            <= '0;
      smp             <= 1'b0;
      o_miso          <= 1'b0;
    end else begin
      state           <= state_n;
      acnt            <= acnt_n;
      asr             <= asr_n;
      sram.sram_raddr <= raddr_n;
      sram.sram_ren   <= ren_n;
      ren_d           <= sram.sram_ren;
      sr              <= sr_n;
      pbuf            <= pbuf_n;
      bcnt            <= bcnt_n;
      smp             <= smp_n;
      o_miso          <= miso_n;
    end
  end

  always_comb begin
    state_n = state;
    acnt_n  = acnt;
    asr_n   = asr;
    raddr_n = sram.sram_raddr;
    ren_n   = 1'b0;
    sr_n    = sr;
    pbuf_n  = pbuf;
    bcnt_n  = bcnt;
    smp_n   = smp;
    miso_n  = o_miso;
    if (state == DATA && ren_d) pbuf_n = sram.sram_rdata;
    if (cs_rise) begin
      state_n = IDLE;
      miso_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state_n = ADDR;
            acnt_n  = '0;
            asr_n   = '0;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            asr_n  = AW'({asr, mosi_s2});
            acnt_n = acnt + 5'd1;
            if (acnt == 5'(ABITS - 1)) begin
              state_n = FETCH;
              ren_n   = 1'b1;
              raddr_n = AW'({asr, mosi_s2});
            end
          end
        end
        FETCH: begin
          if (ren_d) begin
            state_n = DATA;
            sr_n    = sram.sram_rdata;
            miso_n  = sram.sram_rdata[7];
            bcnt_n  = '0;
            smp_n   = 1'b0;
            ren_n   = 1'b1;
            raddr_n = sram.sram_raddr + AW'(1);
          end
        end
        DATA: begin
          // Shift only after the host has sampled the current bit.
          if (sclk_rise) begin
            smp_n = 1'b1;
          end else if (sclk_fall && smp) begin
            smp_n = 1'b0;
            if (bcnt == 3'd7) begin
              sr_n    = pbuf;
              miso_n  = pbuf[7];
              bcnt_n  = '0;
              ren_n   = 1'b1;
              raddr_n = sram.sram_raddr + AW'(1);
            end else begin
              sr_n   = {sr[6:0], 1'b0};
              miso_n = sr[6];
              bcnt_n = bcnt + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_RAM_DUMPER_MISO_OE_EN
  assign o_miso_oe = (state != IDLE);
`endif

endmodule

// File: tb/tb_spi_ram_dumper.sv
// tb_spi_ram_dumper: directed and random SPI reads against an array model.
// Runs an AW=8 and an AW=12 instance side by side on a shared SCLK/MOSI.
module tb_spi_ram_dumper;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk  = 1'b0;
  logic mosi  = 1'b0;
  logic cs8   = 1'b1;
  logic cs12  = 1'b1;
  logic miso8, miso12;

  int checks   = 0;
  int failures = 0;
  int H        = 40;

  logic [7:0]  mem8  [256];
  logic [7:0]  mem12 [4096];
  logic [11:0] rq8   [$];
  logic [11:0] rq12  [$];
  logic [7:0]  got   [$];

  always #5 clk = ~clk;

  spi_ram_dumper_if #(.AW(8))  bus8 ();
  spi_ram_dumper_if #(.AW(12)) bus12 ();

`ifdef SPI_RAM_DUMPER_MISO_OE_EN
  logic oe8, oe12;
`endif

  spi_ram_dumper #(.AW(8)) dut8 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_sclk (sclk),
    .i_cs_n (cs8),
    .i_mosi (mosi),
    .o_miso (miso8),
`ifdef SPI_RAM_DUMPER_MISO_OE_EN
    .o_miso_oe(oe8),
`endif
    .sram   (bus8)
  );

  spi_ram_dumper #(.AW(12)) dut12 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_sclk (sclk),
    .i_cs_n (cs12),
    .i_mosi (mosi),
    .o_miso (miso12),
`ifdef SPI_RAM_DUMPER_MISO_OE_EN
    .o_miso_oe(oe12),
`endif
    .sram   (bus12)
  );

  always @(posedge clk) begin
    if (bus8.sram_ren)  bus8.sram_rdata  <= mem8[bus8.sram_raddr];
    if (bus12.sram_ren) bus12.sram_rdata <= mem12[bus12.sram_raddr];
  end

  always @(negedge clk) begin
    if (bus8.sram_ren)  rq8.push_back(12'(bus8.sram_raddr));
    if (bus12.sram_ren) rq12.push_back(bus12.sram_raddr);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int sel, input int a);
    return sel ? mem12[12'(a)] : mem8[8'(a)];
  endfunction

  task automatic phase(input int off);
    int m;
    m = int'($time % 10);
    #((off - m + 10) % 10);
  endtask

  task automatic sbit(input int sel, input logic b, output logic smp);
    mosi = b;
    #(H);
    sclk = 1'b1;
    #(H);
    smp  = sel ? miso12 : miso8;
    sclk = 1'b0;
  endtask

  task automatic xfer(input int sel, input int addr, input int nab,
                      input int nbits);
    logic s;
    logic [7:0] cur;
    cur = '0;
    got.delete();
    if (sel) rq12.delete(); else rq8.delete();
    if (sel) cs12 = 1'b0; else cs8 = 1'b0;
    #(2 * H);
    for (int i = nab * 8 - 1; i >= 0; i--) sbit(sel, addr[i], s);
    for (int i = 0; i < nbits; i++) begin
      sbit(sel, 1'($urandom), s);
      cur = {cur[6:0], s};
      if (i % 8 == 7) got.push_back(cur);
`ifdef SPI_RAM_DUMPER_MISO_OE_EN
      chk("oe_window", sel ? oe12 : oe8, 1);
`endif
    end
  endtask

  task automatic desel(input int sel);
    if (sel) cs12 = 1'b1; else cs8 = 1'b1;
    #(4 * H);
`ifdef SPI_RAM_DUMPER_MISO_OE_EN
    chk("oe_idle", sel ? oe12 : oe8, 0);
`endif
  endtask

  // Expected: byte k is mem[(start+k) mod 2^AW]; ren addresses
  // follow the same sequence, with at most one lookahead read.
  task automatic check_burst(input string tag, input int sel,
                             input int start, input int n);
    int sz, msk;
    msk = sel ? 4095 : 255;
    chk({tag, "_nbytes"}, got.size(), n);
    for (int k = 0; k < n && k < got.size(); k++)
      chk({tag, "_byte"}, got[k], ref_byte(sel, start + k));
    sz = sel ? rq12.size() : rq8.size();
    chk({tag, "_ren_count"}, 32'(sz == n || sz == n + 1), 1);
    for (int k = 0; k < n && k < sz; k++)
      chk({tag, "_raddr"}, sel ? rq12[k] : rq8[k], (start + k) & msk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    int start, n, sz;
    int offs [8] = '{1, 2, 3, 4, 6, 7, 8, 9};

    foreach (mem8[i])  mem8[i]  = 8'($urandom);
    foreach (mem12[i]) mem12[i] = 8'($urandom);
    mem8[8'h10] = 8'hA5;
    mem8[8'h11] = 8'h3C;
    mem8[8'h12] = 8'hFF;
    mem8[8'h13] = 8'h01;
    mem8[8'hFF] = 8'h11;
    mem8[8'h00] = 8'h22;
    mem8[8'h40] = 8'hFF;
    mem8[8'h80] = 8'hFF;
    mem8[8'h81] = 8'hFF;

    #22;
    chk("rst_miso", miso8, 0);
    chk("rst_ren", bus8.sram_ren, 0);
    chk("rst_raddr", bus8.sram_raddr, 0);
`ifdef SPI_RAM_DUMPER_MISO_OE_EN
    chk("rst_oe", oe8, 0);
`endif
    #1 rst_n = 1'b1;
    #20;
    phase(3);

    xfer(0, 'h10, 1, 32);
    chk("basic_b0", got.size() > 0 ? got[0] : 8'h00, 8'hA5);
    check_burst("basic", 0, 'h10, 4);
    desel(0);

    xfer(0, 'hFF, 1, 16);
    check_burst("wrap", 0, 'hFF, 2);
    desel(0);

    xfer(1, 'hF234, 2, 8);
    check_burst("multi", 1, 'h234, 1);
    desel(1);

    xfer(0, 'h40, 1, 5);
    sz = rq8.size();
    cs8 = 1'b1;
    #100;
    chk("abort_miso", miso8, 0);
    chk("abort_no_ren", rq8.size(), sz);
`ifdef SPI_RAM_DUMPER_MISO_OE_EN
    chk("abort_oe", oe8, 0);
`endif
    #(4 * H);
    xfer(0, 'h20, 1, 16);
    check_burst("reselect", 0, 'h20, 2);
    desel(0);

    xfer(0, 'h80, 1, 12);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", miso8, 0);
    chk("mid_rst_ren", bus8.sram_ren, 0);
    chk("mid_rst_raddr", bus8.sram_raddr, 0);
    #19 rst_n = 1'b1;
    #20;
    sz = rq8.size();
    for (int i = 0; i < 16; i++) begin
      sbit(0, 1'($urandom), s);
      chk("post_rst_idle_miso", s, 0);
    end
    chk("post_rst_no_ren", rq8.size(), sz);
    desel(0);
    xfer(0, 'h80, 1, 16);
    check_burst("post_rst", 0, 'h80, 2);
    desel(0);

    for (int r = 0; r < 3; r++) begin
      start = $urandom_range(0, 255);
      n = $urandom_range(1, 6);
      xfer(0, start, 1, 8 * n);
      check_burst("rand8", 0, start, n);
      desel(0);
    end
    for (int r = 0; r < 2; r++) begin
      start = $urandom_range(0, 65535);
      n = $urandom_range(1, 4);
      xfer(1, start, 2, 8 * n);
      check_burst("rand12", 1, start & 4095, n);
      desel(1);
    end

    H = 20;
    phase(offs[$urandom_range(0, 7)]);
    start = $urandom_range(0, 255);
    xfer(0, start, 1, 2048);
    check_burst("ratio4", 0, start, 256);
    desel(0);
    start = $urandom_range(0, 65535);
    xfer(1, start, 2, 24);
    check_burst("ratio4_12", 1, start & 4095, 3);
    desel(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
